// File: rtl/ir_duty_cal_if.sv
// Handshake bundle between the IR duty calibrator and its controller / IR front end.
interface ir_duty_cal_if;
  logic       cal_start;
  logic       smpl_strobe;
  logic       lftIR;
  logic       cntrIR;
  logic       rghtIR;
  logic [2:0] duty;
  logic       cal_busy;
  logic       cal_done;
  logic       cal_fail;

  modport master (
    output cal_start, smpl_strobe, lftIR, cntrIR, rghtIR,
    input  duty, cal_busy, cal_done, cal_fail
  );

  modport slave (
    input  cal_start, smpl_strobe, lftIR, cntrIR, rghtIR,
    output duty, cal_busy, cal_done, cal_fail
  );
endinterface

// File: rtl/ir_duty_cal.sv
// IR emitter duty calibration: steps duty 1..7, settles, accumulates sensor hits,
// and stops at the first duty whose center sensor dominates the side sensors.
module ir_duty_cal #(
  parameter int          SETTLE_SMPLS = 2,
  parameter int          NUM_SMPLS    = 8,
  parameter logic [2:0]  DFLT_DUTY    = 3'b101
) (
  input  logic         clk,
  input  logic         rst,
  ir_duty_cal_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] ACCUM  = 3'd2;
  localparam logic [2:0] EVAL   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_SMPLS - 1);
  localparam logic [3:0] NUM_LAST    = 4'(NUM_SMPLS - 1);
  // Below two samples the center threshold degenerates to "always enough".
  localparam int         CNTR_MIN    = (NUM_SMPLS > 2) ? NUM_SMPLS - 2 : 0;
  localparam logic [3:0] CNTR_MIN4   = 4'(CNTR_MIN);

  logic [2:0] state;
  logic [2:0] duty_q;
  logic       fail_q;
  logic [3:0] settle_cnt;
  logic [3:0] smpl_cnt;
  logic [3:0] lft_hits;
  logic [3:0] cntr_hits;
  logic [3:0] rght_hits;
  logic       pass;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic hit);
    return (hit && v != 4'hF) ? v + 4'd1 : v;
  endfunction

  assign pass = (cntr_hits >= CNTR_MIN4) && (lft_hits <= 4'd1) && (rght_hits <= 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      duty_q     <= DFLT_DUTY;
      fail_q     <= 1'b0;
      settle_cnt <= 4'd0;
      smpl_cnt   <= 4'd0;
      lft_hits   <= 4'd0;
      cntr_hits  <= 4'd0;
      rght_hits  <= 4'd0;
    end else begin
      case (state)
        IDLE: if (bus.cal_start) begin
          duty_q     <= 3'd1;
          fail_q     <= 1'b0;
          settle_cnt <= 4'd0;
          smpl_cnt   <= 4'd0;
          lft_hits   <= 4'd0;
          cntr_hits  <= 4'd0;
          rght_hits  <= 4'd0;
          state      <= SETTLE;
        end
        SETTLE: if (bus.smpl_strobe) begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 4'd0;
            state      <= ACCUM;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ACCUM: if (bus.smpl_strobe) begin
          smpl_cnt  <= smpl_cnt + 4'd1;
          lft_hits  <= sat_inc(lft_hits,  bus.lftIR);
          cntr_hits <= sat_inc(cntr_hits, bus.cntrIR);
          rght_hits <= sat_inc(rght_hits, bus.rghtIR);
          if (smpl_cnt == NUM_LAST) state <= EVAL;
        end
        EVAL: begin
          if (pass) begin
            state <= DONE;
          end else if (duty_q == 3'd7) begin
            // Exhausted every duty: fall back to the safe default and flag it.
            duty_q <= DFLT_DUTY;
            fail_q <= 1'b1;
            state  <= DONE;
          end else begin
            duty_q     <= duty_q + 3'd1;
            settle_cnt <= 4'd0;
            smpl_cnt   <= 4'd0;
            lft_hits   <= 4'd0;
            cntr_hits  <= 4'd0;
            rght_hits  <= 4'd0;
            state      <= SETTLE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.duty     = duty_q;
  assign bus.cal_fail = fail_q;
  assign bus.cal_busy = (state == SETTLE) || (state == ACCUM) || (state == EVAL);
  assign bus.cal_done = (state == DONE);

endmodule

// File: tb/tb_ir_duty_cal.sv
// Scoreboarded bench for ir_duty_cal: per-step reading tables drive the DUT and a
// table-level model predicts final duty, fail flag and strobes consumed.
module tb_ir_duty_cal;
  localparam int         S    = 2;
  localparam int         N    = 8;
  localparam int         STEP = S + N;
  localparam logic [2:0] DFLT = 3'b101;

  typedef struct {
    logic [2:0] duty;
    logic       fail;
    int         strobes;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ir_duty_cal_if bus();
  ir_duty_cal #(.SETTLE_SMPLS(S), .NUM_SMPLS(N), .DFLT_DUTY(DFLT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t       sb_q[$];
  logic [2:0] tbl [1:7][0:STEP-1];  // {lft, cntr, rght} per strobe of each duty step
  int         tests = 0, fails = 0;
  int         cyc = 0, n_strb = 0, last_cyc = 0, done_cnt = 0;
  logic       prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // First duty whose accumulation window passes the threshold wins.
  function automatic exp_t model();
    exp_t e;
    e.duty = DFLT; e.fail = 1'b1; e.strobes = 7 * STEP;
    for (int d = 1; d <= 7; d++) begin
      int c, l, r;
      c = 0; l = 0; r = 0;
      for (int i = S; i < STEP; i++) begin
        l += int'(tbl[d][i][2]);
        c += int'(tbl[d][i][1]);
        r += int'(tbl[d][i][0]);
      end
      if (c >= N - 2 && l <= 1 && r <= 1) begin
        e.duty = 3'(d); e.fail = 1'b0; e.strobes = d * STEP;
        return e;
      end
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.cal_done) begin
      done_cnt++;
      check("done_pulse_width", 32'(prev_done), 0);
      check("busy_at_done", 32'(bus.cal_busy), 0);
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got cal_done expected none pending");
      end else begin
        e = sb_q.pop_front();
        check("final_duty", 32'(bus.duty), 32'(e.duty));
        check("final_fail", 32'(bus.cal_fail), 32'(e.fail));
        check("strobes_used", n_strb, e.strobes);
        check("done_latency", cyc - last_cyc, 2);
      end
    end
    prev_done = bus.cal_done;
  end

  task automatic fill(input int d_lo, input int d_hi, input logic [2:0] settle_rd, input logic [2:0] acc_rd);
    for (int d = d_lo; d <= d_hi; d++)
      for (int i = 0; i < STEP; i++) tbl[d][i] = (i < S) ? settle_rd : acc_rd;
  endtask

  task automatic fill_rand();
    for (int d = 1; d <= 7; d++) begin
      int pc, pl, pr;
      pc = int'($urandom_range(55, 100));
      pl = int'($urandom_range(0, 20));
      pr = int'($urandom_range(0, 20));
      for (int i = 0; i < STEP; i++)
        tbl[d][i] = {int'($urandom_range(0, 99)) < pl, int'($urandom_range(0, 99)) < pc,
                     int'($urandom_range(0, 99)) < pr};
    end
  endtask

  task automatic strobe(input logic [2:0] rd, input logic stray);
    repeat ($urandom_range(2, 5)) @(negedge clk);
    check("duty_step", 32'(bus.duty), n_strb / STEP + 1);
    bus.smpl_strobe = 1'b1;
    {bus.lftIR, bus.cntrIR, bus.rghtIR} = rd;
    bus.cal_start = stray;
    n_strb++;
    last_cyc = cyc;
    @(negedge clk);
    bus.smpl_strobe = 1'b0;
    bus.cal_start = 1'b0;
    {bus.lftIR, bus.cntrIR, bus.rghtIR} = 3'($urandom);
  endtask

  // bb: raise cal_start on the cal_done cycle and keep it for the next run.
  task automatic run_cal(input bit bb);
    exp_t e;
    int   t;
    e = model();
    if (!bus.cal_start) begin
      @(negedge clk);
      bus.cal_start = 1'b1;
    end
    sb_q.push_back(e);
    n_strb = 0;
    @(negedge clk);
    bus.cal_start = 1'b0;
    check("busy_after_start", 32'(bus.cal_busy), 1);
    check("duty_load", 32'(bus.duty), 1);
    check("fail_cleared", 32'(bus.cal_fail), 0);
    for (int k = 0; k < e.strobes; k++)
      strobe(tbl[k / STEP + 1][k % STEP], $urandom_range(0, 7) == 0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.cal_done && t < 20);
    if (!bus.cal_done) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no cal_done expected one within 20 cycles");
      void'(sb_q.pop_front());
    end
    if (bb) begin
      bus.cal_start = 1'b1;
      @(negedge clk);
      check("start_on_done_ignored", 32'(bus.cal_busy), 0);
    end else begin
      repeat (4) begin
        @(negedge clk);
        bus.smpl_strobe = 1'($urandom);
        {bus.lftIR, bus.cntrIR, bus.rghtIR} = 3'($urandom);
      end
      @(negedge clk);
      bus.smpl_strobe = 1'b0;
      check("hold_duty", 32'(bus.duty), 32'(e.duty));
      check("hold_fail", 32'(bus.cal_fail), 32'(e.fail));
      check("idle_not_busy", 32'(bus.cal_busy), 0);
    end
  endtask

  initial begin
    int dc;
    bus.cal_start = 1'b0; bus.smpl_strobe = 1'b0;
    bus.lftIR = 1'b0; bus.cntrIR = 1'b0; bus.rghtIR = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_duty", 32'(bus.duty), 32'(DFLT));
    check("rst_busy", 32'(bus.cal_busy), 0);
    check("rst_done", 32'(bus.cal_done), 0);
    check("rst_fail", 32'(bus.cal_fail), 0);
    rst = 1'b0;

    // pass at duty 1, then back-to-back into pass at duty 4
    fill(1, 7, 3'b010, 3'b010);
    run_cal(1'b1);
    fill(1, 3, 3'b010, 3'b000);
    fill(4, 7, 3'b000, 3'b010);
    run_cal(1'b0);

    // lft always set: every duty fails
    fill(1, 7, 3'b110, 3'b110);
    run_cal(1'b0);

    // exact threshold: 6 of 8 center hits with one lft hit passes at duty 1
    fill(1, 7, 3'b101, 3'b010);
    for (int i = S + 6; i < STEP; i++) tbl[1][i] = 3'b000;
    tbl[1][S] = 3'b110;
    run_cal(1'b0);

    // 5 of 8 center fails, lft 2 fails, rght 2 fails, then 6/1/1 passes at duty 4
    fill(1, 7, 3'b101, 3'b010);
    for (int i = S + 5; i < STEP; i++) tbl[1][i] = 3'b000;
    tbl[2][S] = 3'b110; tbl[2][S+1] = 3'b110;
    tbl[3][S] = 3'b011; tbl[3][S+1] = 3'b011;
    for (int i = S + 6; i < STEP; i++) tbl[4][i] = 3'b000;
    tbl[4][S] = 3'b110; tbl[4][S+1] = 3'b011;
    run_cal(1'b0);

    // settle readings are bad but discarded
    fill(1, 7, 3'b101, 3'b010);
    run_cal(1'b0);

    // reset in the middle of ACCUM at duty 3
    fill(1, 2, 3'b110, 3'b110);
    fill(3, 7, 3'b010, 3'b010);
    dc = done_cnt;
    @(negedge clk); bus.cal_start = 1'b1;
    n_strb = 0;
    @(negedge clk); bus.cal_start = 1'b0;
    for (int k = 0; k < 2 * STEP + S + 3; k++) strobe(tbl[k / STEP + 1][k % STEP], 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_duty", 32'(bus.duty), 32'(DFLT));
    check("midrst_busy", 32'(bus.cal_busy), 0);
    check("midrst_done", 32'(bus.cal_done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      bus.smpl_strobe = 1'($urandom);
    end
    @(negedge clk);
    bus.smpl_strobe = 1'b0;
    check("postrst_idle", 32'(bus.cal_busy), 0);
    check("postrst_no_done", done_cnt, dc);

    for (int r = 0; r < 25; r++) begin
      fill_rand();
      run_cal(r != 24 && $urandom_range(0, 3) == 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    tests++; fails++;
    $display("FAIL global_timeout: got no completion expected finish before 500000");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
